// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: one register file, one ALU and one req/ready memory port
// shared across FETCH/DECODE/EXEC/MEM/WB. Define MC_BNE_EN to add bne (opcode 0x05).
module mips_multicycle_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int REG_N  = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              retire,
    output logic              halted
);

    localparam int RIDX_W = (REG_N > 1) ? $clog2(REG_N) : 1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
`endif
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_SLT    = 6'h2A;

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] rf_q [REG_N];

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [RIDX_W-1:0] rs_idx, rt_idx, rd_idx;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic [DATA_W-1:0] alu_res;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] jmp_tgt;
    logic              is_rtype, r_legal, is_addi, is_lw, is_sw, is_beq, is_bne, is_j;
    logic              is_branch, legal, br_taken;

    logic              rf_we;
    logic [RIDX_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // Instruction decode, always from the latched IR
    always_comb begin
        opcode   = ir_q[31:26];
        funct    = ir_q[5:0];
        rs_idx   = ir_q[21 +: RIDX_W];
        rt_idx   = ir_q[16 +: RIDX_W];
        rd_idx   = ir_q[11 +: RIDX_W];
        imm_sext = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
        br_off   = {imm_sext[ADDR_W-3:0], 2'b00};
        jmp_tgt  = {ir_q[ADDR_W-3:0], 2'b00};
        is_rtype = (opcode == OP_RTYPE);
        r_legal  = is_rtype && (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT});
        is_addi  = (opcode == OP_ADDI);
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);
        is_beq   = (opcode == OP_BEQ);
        is_j     = (opcode == OP_J);
`ifdef MC_BNE_EN
        is_bne   = (opcode == OP_BNE);
`else
        is_bne   = 1'b0;
`endif
        is_branch = is_beq | is_bne;
        legal     = r_legal | is_addi | is_lw | is_sw | is_branch | is_j;
        br_taken  = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q));
    end

    always_comb begin
        rs_val = (rs_idx == '0) ? '0 : rf_q[rs_idx];
        rt_val = (rt_idx == '0) ? '0 : rf_q[rt_idx];
    end

    // Shared ALU: R-type ops, otherwise base + immediate (addi/lw/sw)
    always_comb begin
        alu_res = a_q + imm_sext;
        if (is_rtype) begin
            unique case (funct)
                F_ADD:   alu_res = a_q + b_q;
                F_SUB:   alu_res = a_q - b_q;
                F_AND:   alu_res = a_q & b_q;
                F_OR:    alu_res = a_q | b_q;
                F_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
                default: alu_res = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        unique case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = rs_val;
                b_d = rt_val;
                if (!legal) begin
                    state_d = S_HALT;
                end else if (is_j) begin
                    pc_d    = jmp_tgt;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    if (br_taken) begin
                        pc_d = pc_q + br_off;
                    end
                    state_d = S_FETCH;
                end else begin
                    alu_d   = alu_res;
                    state_d = (is_lw || is_sw) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (is_lw) begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;
        halted    = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = is_rtype ? rd_idx : rt_idx;
        rf_wdata  = is_lw ? mdr_q : alu_q;
        unique case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = {pc_q[ADDR_W-1:2], 2'b00};
            end
            S_DECODE: retire = legal && is_j;
            S_EXEC:   retire = is_branch;
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = is_sw;
                mem_addr  = {alu_q[ADDR_W-1:2], 2'b00};
                mem_wdata = is_sw ? b_q : '0;
                retire    = is_sw && mem_ready;
            end
            S_WB: begin
                rf_we  = 1'b1;
                retire = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign pc_out = pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= '0;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            alu_q <= '0;
            mdr_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            a_q   <= a_d;
            b_q   <= b_d;
            alu_q <= alu_d;
            mdr_q <= mdr_d;
        end
    end

    // Register 0 is never written, so reads of it need no special storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_N; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we && (rf_waddr != '0)) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: ISA-level reference interpreter feeds retire/store
// scoreboards; a memory responder and a retire monitor pop and compare independently.
module tb_mips_multicycle_core;

    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_we, retire, halted;
    logic [7:0]  mem_addr, pc_out;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    mips_multicycle_core #(.DATA_W(32), .ADDR_W(8), .REG_N(32)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_out(pc_out), .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct { int unsigned base; logic [7:0] pc; } ret_t;
    typedef struct { logic [7:0] addr; logic [31:0] data; } st_t;

    ret_t        exp_ret[$];
    st_t         exp_st[$];
    logic [31:0] mem [64];

    int checks = 0, failures = 0;
    int cyc = 0, last_ret_cyc = 0, first_ret_cyc = -1, stall_acc = 0, store_cnt = 0;
    int wait_mode = 0;
    bit pc_pending = 0;
    logic [7:0] pc_exp_next;
    ret_t mon_e;
    st_t  rsp_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_j(input int target);
        return {6'h02, 26'(target >> 2)};
    endfunction

    // Architectural interpreter: runs the loaded image from PC 0 with all registers zero
    task automatic model_run(input int max_steps, output bit halts);
        logic [31:0] r [32];
        logic [31:0] m [64];
        logic [31:0] ir, simm, v;
        logic [7:0]  pc, a;
        int          rs, rt, rd;
        for (int i = 0; i < 32; i++) r[i] = 0;
        for (int i = 0; i < 64; i++) m[i] = mem[i];
        pc = 0;
        halts = 0;
        for (int s = 0; s < max_steps; s++) begin
            ir   = m[pc[7:2]];
            pc   = pc + 8'd4;
            rs   = int'(ir[25:21]);
            rt   = int'(ir[20:16]);
            rd   = int'(ir[15:11]);
            simm = {{16{ir[15]}}, ir[15:0]};
            a    = 8'(r[rs] + simm) & 8'hFC;
            case (ir[31:26])
                6'h00: begin
                    case (ir[5:0])
                        6'h20: v = r[rs] + r[rt];
                        6'h22: v = r[rs] - r[rt];
                        6'h24: v = r[rs] & r[rt];
                        6'h25: v = r[rs] | r[rt];
                        6'h2A: v = ($signed(r[rs]) < $signed(r[rt])) ? 32'd1 : 32'd0;
                        default: begin halts = 1; return; end
                    endcase
                    if (rd != 0) r[rd] = v;
                    exp_ret.push_back('{base: 4, pc: pc});
                end
                6'h08: begin
                    if (rt != 0) r[rt] = r[rs] + simm;
                    exp_ret.push_back('{base: 4, pc: pc});
                end
                6'h23: begin
                    if (rt != 0) r[rt] = m[a[7:2]];
                    exp_ret.push_back('{base: 5, pc: pc});
                end
                6'h2B: begin
                    exp_st.push_back('{addr: a, data: r[rt]});
                    m[a[7:2]] = r[rt];
                    exp_ret.push_back('{base: 4, pc: pc});
                end
                6'h04: begin
                    if (r[rs] == r[rt]) pc = pc + 8'(simm << 2);
                    exp_ret.push_back('{base: 3, pc: pc});
                end
`ifdef MC_BNE_EN
                6'h05: begin
                    if (r[rs] != r[rt]) pc = pc + 8'(simm << 2);
                    exp_ret.push_back('{base: 3, pc: pc});
                end
`endif
                6'h02: begin
                    pc = 8'(ir[25:0] << 2);
                    exp_ret.push_back('{base: 2, pc: pc});
                end
                default: begin halts = 1; return; end
            endcase
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = HALT_W;
        for (int i = 32; i < 64; i++) mem[i] = $urandom;
    endtask

    task automatic start_prog(input int mode, input int max_steps, output bit halts);
        rst = 1'b0;
        #1;
        check("rst_halted", 32'(halted), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        repeat (2) @(negedge clk);
        exp_ret.delete();
        exp_st.delete();
        stall_acc     = 0;
        last_ret_cyc  = 0;
        first_ret_cyc = -1;
        store_cnt     = 0;
        wait_mode     = mode;
        model_run(max_steps, halts);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("first_fetch_req", 32'(mem_req), 1);
        check("first_fetch_addr", 32'(mem_addr), 0);
    endtask

    task automatic finish_prog(input bit halts, input int budget);
        int bad;
        if (halts) begin
            for (int n = 0; n < budget && !halted; n++) @(negedge clk);
            check("halted_set", 32'(halted), 1);
            check("retires_drained", 32'(exp_ret.size()), 0);
            check("stores_drained", 32'(exp_st.size()), 0);
            bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (mem_req || retire || !halted) bad++;
            end
            check("halt_quiet", 32'(bad), 0);
        end else begin
            for (int n = 0; n < budget && exp_ret.size() != 0; n++) @(negedge clk);
            repeat (2) @(negedge clk);
            check("retires_drained", 32'(exp_ret.size()), 0);
            check("stores_drained", 32'(exp_st.size()), 0);
        end
    endtask

    task automatic gen_random();
        int k, op, lim;
        logic [5:0] fns [5];
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
        clear_mem();
        for (int i = 0; i < 16; i++) begin
            k   = int'($urandom_range(0, 9));
            lim = 15 - i;
            if (k <= 2)
                mem[i] = enc_i(6'h08, $urandom_range(0, 7), $urandom_range(1, 7), $urandom_range(0, 65535));
            else if (k <= 5) begin
                op = int'($urandom_range(0, 4));
                mem[i] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), fns[op]);
            end else if (k == 6)
                mem[i] = enc_i(6'h23, 0, $urandom_range(1, 7), 128 + $urandom_range(0, 127));
            else if (k == 7)
                mem[i] = enc_i(6'h2B, 0, $urandom_range(0, 7), 128 + $urandom_range(0, 127));
            else if (k == 8)
                mem[i] = enc_i(6'h04, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, lim));
            else
                mem[i] = enc_j(4 * int'($urandom_range(i + 1, 16)));
        end
        for (int r = 1; r <= 7; r++) mem[15 + r] = enc_i(6'h2B, 0, r, 224 + 4 * r);
        mem[23] = HALT_W;
    endtask

    initial forever begin
        @(posedge clk);
        cyc = rst ? cyc + 1 : 0;
    end

    // Memory responder: drives ready shortly after each edge, commits on the handshake cycle
    initial begin : responder
        bit          in_xfer;
        int          wl;
        logic [7:0]  a0;
        logic        we0;
        logic [31:0] wd0;
        in_xfer = 0;
        wl = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                in_xfer   = 0;
                mem_ready = 1'b0;
            end else if (mem_req) begin
                if (!in_xfer) begin
                    in_xfer = 1;
                    a0  = mem_addr;
                    we0 = mem_we;
                    wd0 = mem_wdata;
                    case (wait_mode)
                        0:       wl = 0;
                        1:       wl = 3;
                        default: wl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                    endcase
                end else begin
                    check("stall_addr_stable", 32'(mem_addr), 32'(a0));
                    check("stall_we_stable", 32'(mem_we), 32'(we0));
                    check("stall_wdata_stable", mem_wdata, wd0);
                end
                if (wl > 0) begin
                    mem_ready = 1'b0;
                    wl--;
                    stall_acc++;
                    mem_rdata = $urandom;
                end else begin
                    mem_ready = 1'b1;
                    in_xfer   = 0;
                    if (mem_we) begin
                        store_cnt++;
                        if (exp_st.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_store: got addr %0h data %0h, required none", mem_addr, mem_wdata);
                        end else begin
                            rsp_e = exp_st.pop_front();
                            check("store_addr", 32'(mem_addr), 32'(rsp_e.addr));
                            check("store_data", mem_wdata, rsp_e.data);
                        end
                        mem[mem_addr[7:2]] = mem_wdata;
                    end else begin
                        mem_rdata = mem[mem_addr[7:2]];
                    end
                end
            end else begin
                in_xfer   = 0;
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
    end

    initial forever begin : monitor
        @(negedge clk);
        if (!rst) begin
            pc_pending = 0;
        end else begin
            if (pc_pending) begin
                check("pc_after_retire", 32'(pc_out), 32'(pc_exp_next));
                pc_pending = 0;
            end
            if (retire) begin
                if (exp_ret.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_retire: got retire at cycle %0d, required none", cyc);
                end else begin
                    mon_e = exp_ret.pop_front();
                    check("retire_cycle", 32'(cyc), 32'(last_ret_cyc + int'(mon_e.base) + stall_acc));
                    if (first_ret_cyc < 0) first_ret_cyc = cyc;
                    last_ret_cyc = cyc;
                    stall_acc    = 0;
                    pc_pending   = 1;
                    pc_exp_next  = mon_e.pc;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit h;
        bit found;
        #1;
        check("reset_mem_req", 32'(mem_req), 0);
        check("reset_mem_we", 32'(mem_we), 0);
        check("reset_mem_addr", 32'(mem_addr), 0);
        check("reset_mem_wdata", mem_wdata, 0);
        check("reset_pc_out", 32'(pc_out), 0);
        check("reset_retire", 32'(retire), 0);
        check("reset_halted", 32'(halted), 0);

        clear_mem();
        mem[0] = enc_i(6'h08, 0, 1, 5);
        mem[1] = enc_i(6'h08, 0, 2, 7);
        mem[2] = enc_r(1, 2, 3, 6'h20);
        mem[3] = enc_i(6'h2B, 0, 3, 16);
        start_prog(0, 100, h);
        finish_prog(h, 300);
        check("zw_last_retire_cycles", 32'(last_ret_cyc + 1), 17);
        check("zw_store_count", 32'(store_cnt), 1);

        clear_mem();
        mem[0] = enc_i(6'h23, 0, 5, 128);
        mem[1] = enc_i(6'h2B, 0, 5, 132);
        start_prog(1, 100, h);
        finish_prog(h, 300);
        check("lw_wait_retire_cycle", 32'(first_ret_cyc), 11);

        clear_mem();
        mem[0] = enc_i(6'h08, 0, 1, 3);
        mem[1] = enc_i(6'h08, 0, 2, 4);
        mem[2] = enc_i(6'h04, 1, 1, -1);
        start_prog(0, 7, h);
        finish_prog(h, 300);
        check("beq_loop_last_retire", 32'(last_ret_cyc), 23);

        mem[2] = enc_i(6'h04, 1, 2, 5);
        mem[3] = HALT_W;
        start_prog(0, 100, h);
        finish_prog(h, 300);

        clear_mem();
        mem[0] = enc_i(6'h08, 0, 0, 9);
        mem[1] = enc_r(0, 0, 4, 6'h20);
        mem[2] = enc_i(6'h2B, 0, 4, 0);
        start_prog(2, 100, h);
        finish_prog(h, 300);

        clear_mem();
        mem[0] = enc_i(6'h08, 0, 1, 1);
        mem[1] = HALT_W;
        start_prog(0, 100, h);
        finish_prog(h, 300);

        clear_mem();
        mem[0] = enc_i(6'h08, 0, 1, 1);
        mem[1] = enc_i(6'h08, 0, 2, 2);
        mem[2] = enc_i(6'h05, 1, 2, 2);
        mem[3] = enc_i(6'h2B, 0, 1, 200);
        mem[4] = enc_i(6'h2B, 0, 2, 204);
        mem[5] = HALT_W;
        start_prog(2, 100, h);
        finish_prog(h, 300);

        clear_mem();
        mem[0] = enc_i(6'h08, 0, 1, 7);
        mem[1] = enc_i(6'h08, 0, 2, 9);
        mem[2] = enc_i(6'h23, 0, 3, 128);
        start_prog(1, 100, h);
        found = 0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (mem_req && !mem_we && mem_addr == 8'd128 && !mem_ready) found = 1;
        end
        check("reach_lw_mem_wait", 32'(found), 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_mem_req", 32'(mem_req), 0);
        check("async_rst_pc_out", 32'(pc_out), 0);
        check("async_rst_retire", 32'(retire), 0);
        clear_mem();
        for (int r = 1; r <= 31; r++) mem[r - 1] = enc_i(6'h2B, 0, r, 128 + 4 * (r - 1));
        start_prog(0, 100, h);
        finish_prog(h, 1000);

        for (int t = 0; t < 6; t++) begin
            gen_random();
            start_prog((t == 0) ? 0 : 2, 100, h);
            finish_prog(h, 2000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
